instr_decode_unit: RTL

INSTR_DECODE_UNIT -- requirements
Module: instr_decode_unit

---
 rtl/instr_decode_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/instr_decode_unit.sv
// rtl/instr_decode_unit.sv - RV32I decode stage with a single registered output slot
// Define RV_M_EXT_EN to decode the OP/funct7=0000001 group as MULDIV instead of ILLEGAL.
module instr_decode_unit #(
  parameter int XLEN            = 32,
  parameter int CNT_W           = 16,
  parameter int HALT_ON_ILLEGAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_class,
  output logic [3:0]       out_alu_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic             halted,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] CLS_ALU_R  = 4'd0;
  localparam logic [3:0] CLS_ALU_I  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_FENCE  = 4'd9;
  localparam logic [3:0] CLS_MULDIV = 4'd10;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_valid;
  logic [XLEN-1:0]  r_pc, r_imm;
  logic [3:0]       r_cls, r_alu_op;
  logic [4:0]       r_rd, r_rs1, r_rs2;
  logic [CNT_W-1:0] r_dcnt, r_icnt;

  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  logic            w_shift, w_shamt_ok, w_accept;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [3:0]      w_cls, w_alu_op;
  logic            w_rd_en, w_rs1_en, w_rs2_en;
  logic [XLEN-1:0] w_imm;

  assign w_op = in_instr[6:0];
  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];

  assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'h000};
  assign w_imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Shift-immediates carry funct6 in [31:26]; bit 25 is shamt[5], only meaningful for 64-bit.
  assign w_shift    = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_shamt_ok = ((in_instr[31:26] == 6'b000000) || (in_instr[31:26] == 6'b010000)) &&
                      ((XLEN == 64) || !in_instr[25]);

  always_comb begin
    w_cls    = CLS_ILL;
    w_alu_op = 4'd0;
    w_rd_en  = 1'b0;
    w_rs1_en = 1'b0;
    w_rs2_en = 1'b0;
    w_imm    = '0;
    case (w_op)
      7'b0110111: begin w_cls = CLS_LUI;   w_rd_en = 1'b1; w_imm = w_imm_u; end
      7'b0010111: begin w_cls = CLS_AUIPC; w_rd_en = 1'b1; w_imm = w_imm_u; end
      7'b1101111: begin w_cls = CLS_JAL;   w_rd_en = 1'b1; w_imm = w_imm_j; end
      7'b1100111: if (w_f3 == 3'b000) begin
        w_cls = CLS_JALR; w_rd_en = 1'b1; w_rs1_en = 1'b1; w_imm = w_imm_i;
      end
      7'b1100011: if (w_f3 != 3'b010 && w_f3 != 3'b011) begin
        w_cls = CLS_BRANCH; w_alu_op = {1'b0, w_f3}; w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_imm = w_imm_b;
      end
      7'b0000011: if (w_f3 != 3'b011 && w_f3 != 3'b110 && w_f3 != 3'b111) begin
        w_cls = CLS_LOAD; w_alu_op = {1'b0, w_f3}; w_rd_en = 1'b1; w_rs1_en = 1'b1; w_imm = w_imm_i;
      end
      7'b0100011: if (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010) begin
        w_cls = CLS_STORE; w_alu_op = {1'b0, w_f3}; w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_imm = w_imm_s;
      end
      7'b0010011: if (!w_shift || w_shamt_ok) begin
        w_cls    = CLS_ALU_I;
        w_alu_op = w_shift ? {in_instr[30], w_f3} : {1'b0, w_f3};
        w_rd_en  = 1'b1;
        w_rs1_en = 1'b1;
        w_imm    = w_imm_i;
      end
      7'b0110011: begin
        if (w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
          w_cls = CLS_ALU_R; w_alu_op = {in_instr[30], w_f3};
          w_rd_en = 1'b1; w_rs1_en = 1'b1; w_rs2_en = 1'b1;
        end
`ifdef RV_M_EXT_EN
        else if (w_f7 == 7'b0000001) begin
          w_cls = CLS_MULDIV; w_alu_op = {1'b0, w_f3};
          w_rd_en = 1'b1; w_rs1_en = 1'b1; w_rs2_en = 1'b1;
        end
`endif
      end
      7'b0001111: if (w_f3 == 3'b000 || w_f3 == 3'b001) begin
        w_cls = CLS_FENCE; w_rd_en = 1'b1; w_rs1_en = 1'b1; w_imm = w_imm_i;
      end
      default: ;
    endcase
  end

  assign in_ready = !reset && (r_state == S_RUN) && !flush && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:  if (w_accept && (w_cls == CLS_ILL) && (HALT_ON_ILLEGAL != 0)) w_state_nxt = S_HALT;
      S_HALT: if (flush) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_imm    <= '0;
      r_cls    <= 4'd0;
      r_alu_op <= 4'd0;
      r_rd     <= 5'd0;
      r_rs1    <= 5'd0;
      r_rs2    <= 5'd0;
      r_dcnt   <= '0;
      r_icnt   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_pc     <= in_pc;
      r_imm    <= w_imm;
      r_cls    <= w_cls;
      r_alu_op <= w_alu_op;
      r_rd     <= w_rd_en  ? in_instr[11:7]  : 5'd0;
      r_rs1    <= w_rs1_en ? in_instr[19:15] : 5'd0;
      r_rs2    <= w_rs2_en ? in_instr[24:20] : 5'd0;
      if (r_dcnt != {CNT_W{1'b1}}) r_dcnt <= r_dcnt + CNT_W'(1);
      if ((w_cls == CLS_ILL) && (r_icnt != {CNT_W{1'b1}})) r_icnt <= r_icnt + CNT_W'(1);
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_class   = r_cls;
  assign out_alu_op  = r_alu_op;
  assign out_rd      = r_rd;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_imm     = r_imm;
  assign out_illegal = (r_cls == CLS_ILL);
  assign halted      = (r_state == S_HALT);
  assign decoded_cnt = r_dcnt;
  assign illegal_cnt = r_icnt;

endmodule
